// File: rtl/req_capture_encoder.sv
// req_capture_encoder: latches request lines into sticky pending bits and hands out one
// pending index per valid/ready transfer, with fixed or round-robin priority.
module req_capture_encoder #(
  parameter int N = 8,
  parameter int W = 3,
  parameter int EDGE = 1,
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic [N-1:0] pending,
  output logic         overrun,
  input  logic         clr_ovr
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [N-1:0] req_d, hit, acc_vec, cand;
  logic [W-1:0] rr_ptr, sel, idx;
  logic acc, found;
  assign hit = EDGE != 0 ? req & ~req_d : req;
  assign acc = out_valid & out_ready;
  assign acc_vec = acc ? N'(1) << out_code : '0;
  // the index being accepted drops out of the candidate set so the next grant can follow at once
  assign cand = pending & ~mask & ~acc_vec;
  always_comb begin
    sel = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = RR != 0 ? rr_ptr + W'(k) : W'(k);
      if (!found && cand[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_code <= '0;
      req_d <= '0;
      pending <= '0;
      overrun <= 1'b0;
      rr_ptr <= '0;
    end else begin
      req_d <= req;
      pending <= (pending & ~acc_vec) | hit;
      overrun <= (overrun & ~clr_ovr) | |(hit & pending & ~acc_vec);
      if (acc && RR != 0) rr_ptr <= out_code + 1'b1;
      if (state == IDLE && found) begin
        state <= HOLD;
        out_valid <= 1'b1;
        out_code <= sel;
      end else if (state == HOLD && acc) begin
        state <= found ? HOLD : IDLE;
        out_valid <= found;
        if (found) out_code <= sel;
      end
    end
  end
endmodule

// File: tb/tb_req_capture_encoder.sv
// tb_req_capture_encoder: edge/fixed and level/round-robin instances against a cycle model,
// transfers checked through per-instance scoreboard queues.
module tb_req_capture_encoder;
  logic clk = 0, rst = 1;
  logic [7:0] req = 0, mask = 0;
  logic out_ready = 0, clr_ovr = 0;
  logic v0, v1, o0, o1;
  logic [2:0] c0, c1;
  logic [7:0] p0, p1;
  int tests = 0, fails = 0;
  logic [2:0] q0[$], q1[$];
  typedef struct packed {
    logic [7:0] pend, reqd;
    logic valid;
    logic [2:0] code;
    logic ovr;
    logic [2:0] ptr;
  } mst_t;
  mst_t m0, m1;

  always #5 clk = ~clk;

  req_capture_encoder #(.EDGE(1), .RR(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .out_valid(v0), .out_ready(out_ready),
    .out_code(c0), .pending(p0), .overrun(o0), .clr_ovr(clr_ovr));
  req_capture_encoder #(.EDGE(0), .RR(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .out_valid(v1), .out_ready(out_ready),
    .out_code(c1), .pending(p1), .overrun(o1), .clr_ovr(clr_ovr));

  function automatic mst_t mstep(mst_t s, bit edg, bit rr, logic [7:0] rq, logic [7:0] mk, logic rdy, logic cl);
    mst_t n = s;
    logic [7:0] hit = edg ? rq & ~s.reqd : rq;
    logic [7:0] taken = 0;
    logic [7:0] cand;
    bit acc = s.valid && rdy;
    int pick = -1;
    if (acc) taken[s.code] = 1;
    cand = s.pend & ~mk & ~taken;
    for (int k = 0; k < 8; k++) begin
      int i = rr ? (int'(s.ptr) + k) % 8 : k;
      if (pick < 0 && cand[i]) pick = i;
    end
    n.reqd = rq;
    n.pend = (s.pend & ~taken) | hit;
    n.ovr = (cl ? 1'b0 : s.ovr) | ((hit & s.pend & ~taken) != 0);
    if (acc && rr) n.ptr = 3'((int'(s.code) + 1) % 8);
    if (!s.valid || acc) begin
      n.valid = pick >= 0;
      if (pick >= 0) n.code = 3'(pick);
    end
    return n;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] rq, input logic [7:0] mk, input logic rdy, input logic cl);
    @(negedge clk);
    check("valid0", {7'd0, v0}, {7'd0, m0.valid});
    if (m0.valid) check("code0", {5'd0, c0}, {5'd0, m0.code});
    check("pend0", p0, m0.pend);
    check("ovr0", {7'd0, o0}, {7'd0, m0.ovr});
    check("valid1", {7'd0, v1}, {7'd0, m1.valid});
    if (m1.valid) check("code1", {5'd0, c1}, {5'd0, m1.code});
    check("pend1", p1, m1.pend);
    check("ovr1", {7'd0, o1}, {7'd0, m1.ovr});
    req = rq;
    mask = mk;
    out_ready = rdy;
    clr_ovr = cl;
    if (m0.valid && rdy) q0.push_back(m0.code);
    if (m1.valid && rdy) q1.push_back(m1.code);
    m0 = mstep(m0, 1, 0, rq, mk, rdy, cl);
    m1 = mstep(m1, 0, 1, rq, mk, rdy, cl);
  endtask

  // reset lands between clock edges; outputs must drop without waiting for a clock
  task automatic do_reset(input logic [7:0] rq);
    @(negedge clk);
    req = rq;
    out_ready = 0;
    #1 rst = 1;
    #1;
    check("rst_valid0", {7'd0, v0}, 8'd0);
    check("rst_pend0", p0, 8'd0);
    check("rst_valid1", {7'd0, v1}, 8'd0);
    check("rst_pend1", p1, 8'd0);
    m0 = '0;
    m1 = '0;
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (!rst && v0 && out_ready) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL xfer0: got code %0d expected no transfer", c0);
      end else check("xfer0", {5'd0, c0}, {5'd0, q0.pop_front()});
    end
    if (!rst && v1 && out_ready) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL xfer1: got code %0d expected no transfer", c1);
      end else check("xfer1", {5'd0, c1}, {5'd0, q1.pop_front()});
    end
  end

  initial begin
    m0 = '0;
    m1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(8'(1 << i), 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
    end
    repeat (3) cyc(0, 0, 1, 0);
    cyc(8'hA4, 0, 1, 0);
    repeat (5) cyc(0, 0, 1, 0);
    repeat (8) cyc(8'h11, 0, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);
    cyc(8'h08, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(8'h02, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0);
    cyc(8'h40, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(8'h40, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(8'h40, 0, 1, 0);
    repeat (4) cyc(0, 0, 1, 0);
    cyc(8'h03, 8'h01, 1, 0);
    repeat (4) cyc(0, 8'h01, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(8'h08, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    do_reset(8'h01);
    repeat (4) cyc(8'h01, 0, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);
    for (int i = 0; i < 1500; i++) begin
      if (i % 400 == 399) do_reset(8'($urandom));
      cyc($urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00,
          $urandom_range(0, 5) == 0 ? 8'($urandom) : 8'h00,
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (20) cyc(0, 0, 1, 0);
    @(negedge clk);
    #3;
    check("q0_drained", 8'(q0.size()), 8'd0);
    check("q1_drained", 8'(q1.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
